// File: rtl/ram_refresh_scheduler_if.sv
// Refresh request/acknowledge bundle between the refresh scheduler (master)
// and the RAM sequencer (slave).
interface ram_refresh_scheduler_if #(
   parameter int unsigned PEND_W = 4
);
   logic              En;
   logic              RefAck;
   logic              RefReq;
   logic              RefUrg;
   logic [PEND_W-1:0] RefPend;
   logic              Overrun;
   logic              InitDone;

   modport master (
      input  En,
      input  RefAck,
      output RefReq,
      output RefUrg,
      output RefPend,
      output Overrun,
      output InitDone
   );

   modport slave (
      output En,
      output RefAck,
      input  RefReq,
      input  RefUrg,
      input  RefPend,
      input  Overrun,
      input  InitDone
   );
endinterface

// File: rtl/ram_refresh_scheduler.sv
// DRAM refresh scheduler: times refresh intervals, counts owed refreshes,
// escalates urgency and issues the power-on init burst.
module ram_refresh_scheduler #(
   parameter int unsigned INTERVAL   = 390,
   parameter int unsigned CNT_W      = 9,
   parameter int unsigned PEND_W     = 4,
   parameter int unsigned URG_THRESH = 2,
   parameter int unsigned AGE_W      = 8,
   parameter int unsigned URG_AGE    = 128,
   parameter int unsigned INIT_BURST = 8
) (
   input logic                     CLK,
   input logic                     Reset,
   ram_refresh_scheduler_if.master bus
);
   // Two spare bits hold the unclamped sum: pend + due + burst can reach 2*max+1.
   localparam int unsigned PW       = PEND_W + 2;
   localparam int unsigned PEND_MAX = (1 << PEND_W) - 1;

   logic [CNT_W-1:0]  intervalCnt, intervalCntNext;
   logic [AGE_W-1:0]  age, ageNext;
   logic [PEND_W-1:0] pend, pendNext;
   logic [PW-1:0]     pSum;
   logic              start, due, ackV, sat;
   logic              refReq, refUrg, overrun, initDone;

   always_comb begin
      due             = 1'b0;
      intervalCntNext = '0;
      if (bus.En) begin
         if (intervalCnt == CNT_W'(INTERVAL - 1)) begin
            due = 1'b1;
         end else begin
            intervalCntNext = intervalCnt + CNT_W'(1);
         end
      end

      ackV = bus.RefAck && (pend != '0);
      pSum = PW'(pend) + PW'(due) + (start ? PW'(INIT_BURST) : PW'(0)) - PW'(ackV);
      sat  = (pSum > PW'(PEND_MAX));
      pendNext = sat ? PEND_W'(PEND_MAX) : pSum[PEND_W-1:0];

      if (ackV || (pSum == '0)) begin
         ageNext = '0;
      end else if ((pend != '0) && (age != '1)) begin
         ageNext = age + AGE_W'(1);
      end else begin
         ageNext = age;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         intervalCnt <= '0;
         age         <= '0;
         pend        <= '0;
         refReq      <= 1'b0;
         refUrg      <= 1'b0;
         overrun     <= 1'b0;
         initDone    <= 1'b0;
         start       <= 1'b1;
      end else begin
         intervalCnt <= intervalCntNext;
         age         <= ageNext;
         pend        <= pendNext;
         refReq      <= (pSum != '0);
         refUrg      <= (pSum >= PW'(URG_THRESH)) || (ageNext >= AGE_W'(URG_AGE));
         overrun     <= overrun | sat;
         // Only a drain after the burst has been loaded counts as init complete.
         initDone    <= initDone | (!start && (pSum == '0));
         start       <= 1'b0;
      end
   end

   assign bus.RefReq   = refReq;
   assign bus.RefUrg   = refUrg;
   assign bus.RefPend  = pend;
   assign bus.Overrun  = overrun;
   assign bus.InitDone = initDone;
endmodule

// File: tb/tb_ram_refresh_scheduler.sv
// Directed and randomized bench for ram_refresh_scheduler against a
// cycle-level reference model of the owed-refresh bookkeeping.
module tb_ram_refresh_scheduler;
   localparam int INTERVAL = 390;
   localparam int PMAX     = 15;
   localparam int BURST    = 8;
   localparam int AMAX     = 255;

   logic CLK = 1'b0;
   logic Reset;
   int   checks = 0;
   int   errors = 0;

   ram_refresh_scheduler_if #(.PEND_W(4)) bus ();

   ram_refresh_scheduler dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Reference model state
   int mPend, mAge, mEnRun;
   bit mReq, mUrg, mOvr, mDone, mStart;

   task automatic checkVal(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock worth of bookkeeping, from the inputs presented this cycle.
   task automatic modelStep();
      int p;
      bit d, a;
      if (Reset) begin
         mPend = 0; mAge = 0; mEnRun = 0;
         mReq = 0; mUrg = 0; mOvr = 0; mDone = 0; mStart = 1;
      end else begin
         d = bus.En && ((mEnRun % INTERVAL) == INTERVAL - 1);
         mEnRun = bus.En ? mEnRun + 1 : 0;
         a = bus.RefAck && (mPend > 0);
         p = mPend + int'(d) + (mStart ? BURST : 0) - int'(a);
         if (a || p == 0) mAge = 0;
         else if (mPend > 0 && mAge < AMAX) mAge = mAge + 1;
         if (p > PMAX) mOvr = 1;
         if (!mStart && p == 0) mDone = 1;
         mPend  = (p > PMAX) ? PMAX : p;
         mReq   = (mPend != 0);
         mUrg   = (p >= 2) || (mAge >= 128);
         mStart = 0;
      end
   endtask

   task automatic tick();
      modelStep();
      @(posedge CLK);
      #1;
      checkVal("RefPend",  int'(bus.RefPend),  mPend);
      checkVal("RefReq",   int'(bus.RefReq),   int'(mReq));
      checkVal("RefUrg",   int'(bus.RefUrg),   int'(mUrg));
      checkVal("Overrun",  int'(bus.Overrun),  int'(mOvr));
      checkVal("InitDone", int'(bus.InitDone), int'(mDone));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      Reset = 1'b1;
      bus.En = 1'b0;
      bus.RefAck = 1'b0;
      mStart = 1;

      // Reset state
      ticks(3);
      checkVal("rst_pend", int'(bus.RefPend), 0);
      checkVal("rst_req",  int'(bus.RefReq),  0);
      checkVal("rst_done", int'(bus.InitDone), 0);

      // Init burst appears the cycle after release
      Reset = 1'b0;
      tick();
      checkVal("init_pend", int'(bus.RefPend), 8);
      checkVal("init_req",  int'(bus.RefReq),  1);
      checkVal("init_urg",  int'(bus.RefUrg),  1);

      // Service the burst with acks 10 cycles apart
      for (int i = 1; i <= 8; i++) begin
         bus.RefAck = 1'b1;
         tick();
         bus.RefAck = 1'b0;
         if (i == 7) begin
            checkVal("ack7_pend", int'(bus.RefPend), 1);
            checkVal("ack7_urg",  int'(bus.RefUrg),  0);
         end
         if (i == 8) begin
            checkVal("ack8_pend", int'(bus.RefPend), 0);
            checkVal("ack8_req",  int'(bus.RefReq),  0);
            checkVal("ack8_done", int'(bus.InitDone), 1);
         end
         ticks(9);
      end

      // First Due exactly INTERVAL cycles after En rises
      bus.En = 1'b1;
      ticks(389);
      checkVal("due1_early", int'(bus.RefPend), 0);
      tick();
      checkVal("due1_pend", int'(bus.RefPend), 1);
      checkVal("due1_req",  int'(bus.RefReq),  1);
      ticks(127);
      checkVal("age127_urg", int'(bus.RefUrg), 0);
      tick();
      checkVal("age128_urg", int'(bus.RefUrg), 1);
      ticks(261);
      checkVal("due2_early", int'(bus.RefPend), 1);
      tick();
      checkVal("due2_pend", int'(bus.RefPend), 2);

      // Saturation on the 16th Due
      ticks(6239 - 780);
      checkVal("sat_pend15", int'(bus.RefPend), 15);
      checkVal("sat_ovr0",   int'(bus.Overrun), 0);
      tick();
      checkVal("sat_pend",   int'(bus.RefPend), 15);
      checkVal("sat_ovr1",   int'(bus.Overrun), 1);
      bus.RefAck = 1'b1;
      tick();
      checkVal("sat_ack", int'(bus.RefPend), 14);

      // Drain, then an ack with nothing owed
      bus.En = 1'b0;
      ticks(14);
      checkVal("drain_pend", int'(bus.RefPend), 0);
      tick();
      checkVal("idle_pend", int'(bus.RefPend), 0);
      checkVal("idle_req",  int'(bus.RefReq),  0);
      checkVal("idle_ovr",  int'(bus.Overrun), 1);
      bus.RefAck = 1'b0;

      // Due coinciding with an ack while one refresh is owed and urgent by age
      bus.En = 1'b1;
      ticks(390);
      checkVal("coin_pre_pend", int'(bus.RefPend), 1);
      ticks(389);
      checkVal("coin_pre_urg", int'(bus.RefUrg), 1);
      bus.RefAck = 1'b1;
      tick();
      bus.RefAck = 1'b0;
      checkVal("coin_pend", int'(bus.RefPend), 1);
      checkVal("coin_urg",  int'(bus.RefUrg),  0);

      // Reset mid-run with owed refreshes and Overrun set
      ticks(1560);
      checkVal("mid_pend", int'(bus.RefPend), 5);
      checkVal("mid_ovr",  int'(bus.Overrun), 1);
      bus.En = 1'b0;
      Reset = 1'b1;
      tick();
      checkVal("mid_rst_pend", int'(bus.RefPend), 0);
      checkVal("mid_rst_ovr",  int'(bus.Overrun), 0);
      checkVal("mid_rst_urg",  int'(bus.RefUrg),  0);
      Reset = 1'b0;
      tick();
      checkVal("reburst_pend", int'(bus.RefPend), 8);
      checkVal("reburst_req",  int'(bus.RefReq),  1);

      // En dropped partway through an interval restarts timing
      bus.RefAck = 1'b1;
      ticks(8);
      bus.RefAck = 1'b0;
      bus.En = 1'b1;
      ticks(200);
      bus.En = 1'b0;
      tick();
      bus.En = 1'b1;
      ticks(389);
      checkVal("reen_early", int'(bus.RefPend), 0);
      tick();
      checkVal("reen_due", int'(bus.RefPend), 1);

      // Randomized traffic: heavy acks, then sparse acks so refreshes pile up
      for (int i = 0; i < 12000; i++) begin
         Reset      = ($urandom_range(0, 2999) == 0);
         bus.En     = ($urandom_range(0, 19) != 0);
         bus.RefAck = (i < 4000) ? ($urandom_range(0, 9) < 3)
                                 : ($urandom_range(0, 999) < 2);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
